// File: rtl/pc_sequencer_if.sv
// Return-address-stack link between the PC sequencer (master) and the stack (slave).
interface pc_sequencer_if #(
    parameter int unsigned D = 12
);
    logic         ras_call;
    logic         ras_ret;
    logic [D-1:0] ras_addr;
    logic [D-1:0] ras_target_in;
    logic [D-1:0] ras_target;

    modport master (
        output ras_call,
        output ras_ret,
        output ras_addr,
        output ras_target_in,
        input  ras_target
    );

    modport slave (
        input  ras_call,
        input  ras_ret,
        input  ras_addr,
        input  ras_target_in,
        output ras_target
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/call/return/halt flow with call-depth
// tracking so stack overflow and underflow end execution with a sticky error.
module pc_sequencer #(
    parameter int unsigned D           = 12,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned START_ADDR  = 0,
    localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          halt,
    input  logic          branch_taken,
    input  logic          call,
    input  logic          ret,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  pc,
    output logic          instr_valid,
    output logic [DW-1:0] depth,
    output logic          error,
    output logic          done,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRun, StRetWait, StDone} state_e;

    state_e state;

    logic stack_empty;
    logic stack_full;

    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == DW'(STACK_DEPTH));

    assign bus.ras_addr      = pc;
    assign bus.ras_target_in = target;

    // Stack requests follow the same priority as the state update; a reset cycle issues none.
    always_comb begin
        bus.ras_call = 1'b0;
        bus.ras_ret  = 1'b0;
        if (!reset && state == StRun && !halt) begin
            if (ret) begin
                bus.ras_ret = !stack_empty;
            end else if (call) begin
                bus.ras_call = !stack_full;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            pc          <= D'(START_ADDR);
            depth       <= '0;
            error       <= 1'b0;
            done        <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state       <= StRun;
                        pc          <= D'(START_ADDR);
                        depth       <= '0;
                        error       <= 1'b0;
                        done        <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                StRun: begin
                    if (halt) begin
                        state       <= StDone;
                        done        <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (ret) begin
                        instr_valid <= 1'b0;
                        if (stack_empty) begin
                            state <= StDone;
                            error <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state <= StRetWait;
                            depth <= depth - 1'b1;
                        end
                    end else if (call) begin
                        if (stack_full) begin
                            state       <= StDone;
                            error       <= 1'b1;
                            done        <= 1'b1;
                            instr_valid <= 1'b0;
                        end else begin
                            depth <= depth + 1'b1;
                            pc    <= target;
                        end
                    end else if (branch_taken) begin
                        pc <= target;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                StRetWait: begin
                    // Stack output is valid the cycle after the pop request.
                    state       <= StRun;
                    pc          <= bus.ras_target;
                    instr_valid <= 1'b1;
                end
                default: begin
                    state       <= StIdle;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
